alu_operand_stage: RTL and testbench

//  Execute-stage front end directly upstream of the ALU. Accepts a decoded op from the

---
 rtl/alu_pkg.sv | 59 +++++
 rtl/alu_skid_buffer.sv | 76 +++++++
 rtl/alu_operand_stage.sv | 89 ++++++++
 tb/tb_alu_operand_stage.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU encodings, funct3 constants and the operand-stage payload type.
// Imported by the operand stage and its buffer.
package alu_pkg;

    localparam int unsigned ALU_XLEN = 32;

    localparam logic [2:0] ALU_ADD  = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b101;
    localparam logic [2:0] ALU_AND  = 3'b110;
    localparam logic [2:0] ALU_OR   = 3'b111;
    localparam logic [2:0] ALU_XOR  = 3'b000;
    localparam logic [2:0] ALU_SLTU = 3'b001;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef struct packed {
        logic [ALU_XLEN-1:0] op1;
        logic [ALU_XLEN-1:0] op2;
        logic [2:0]          selection;
        logic                illegal;
    } alu_op_t;

    localparam alu_op_t ALU_OP_RESET = '{
        op1:       '0,
        op2:       '0,
        selection: ALU_ADD,
        illegal:   1'b0
    };

    // Returns {illegal, selection}; funct7b5 only selects sub for R-type add.
    function automatic logic [3:0] alu_decode(input logic [2:0] funct3,
                                              input logic       funct7b5,
                                              input logic       use_imm);
        logic       r_sub;
        logic [2:0] sel;
        logic       illegal;
        r_sub   = funct7b5 & ~use_imm;
        sel     = ALU_ADD;
        illegal = 1'b0;
        case (funct3)
            F3_ADD:  sel = r_sub ? ALU_SUB : ALU_ADD;
            F3_AND:  sel = ALU_AND;
            F3_OR:   sel = ALU_OR;
            F3_XOR:  sel = ALU_XOR;
            F3_SLTU: sel = ALU_SLTU;
            default: illegal = 1'b1;
        endcase
        if (r_sub && (funct3 != F3_ADD)) begin
            sel     = ALU_ADD;
            illegal = 1'b1;
        end
        return {illegal, sel};
    endfunction

endpackage

// File: rtl/alu_skid_buffer.sv
// Two-entry valid/ready buffer: a main register that drives the outputs plus one skid entry.
// in_ready is registered and equals "skid empty".
module alu_skid_buffer #(
    parameter int unsigned      Width    = 8,
    parameter logic [Width-1:0] ResetVal = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Width-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Width-1:0] out_data
);

    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [Width-1:0] main_data_q, main_data_d;
    logic [Width-1:0] skid_data_q, skid_data_d;
    logic             accept;
    logic             xfer;

    assign accept = in_valid & in_ready_q;
    assign xfer   = main_valid_q & out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || xfer) begin
            // in_ready is low whenever skid is full, so no accept can coincide with a refill.
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = accept;
                if (accept) begin
                    main_data_d = in_data;
                end
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
        in_ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
            main_data_q  <= ResetVal;
            skid_data_q  <= ResetVal;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;

endmodule

// File: rtl/alu_operand_stage.sv
// Execute-stage front end: resolves EX/WB forwarding, picks reg/imm for op2 and decodes the
// ALU selection, then hands the registered op to the ALU through a 2-deep skid buffer.
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int unsigned XLEN  = ALU_XLEN,
    parameter int unsigned RADDR = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [RADDR-1:0] in_rs1_addr,
    input  logic [RADDR-1:0] in_rs2_addr,
    input  logic [XLEN-1:0]  in_rs1_data,
    input  logic [XLEN-1:0]  in_rs2_data,
    input  logic [XLEN-1:0]  in_imm,
    input  logic             in_use_imm,
    input  logic [2:0]       in_funct3,
    input  logic             in_funct7b5,
    input  logic             fwd_ex_valid,
    input  logic [RADDR-1:0] fwd_ex_rd,
    input  logic [XLEN-1:0]  fwd_ex_data,
    input  logic             fwd_wb_valid,
    input  logic [RADDR-1:0] fwd_wb_rd,
    input  logic [XLEN-1:0]  fwd_wb_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  op1,
    output logic [XLEN-1:0]  op2,
    output logic [2:0]       selection,
    output logic             illegal_op
);

    logic            ex_hit1, wb_hit1;
    logic            ex_hit2, wb_hit2;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic [3:0]      dec;
    alu_op_t         stage_op;
    alu_op_t         out_op;

    always_comb begin
        ex_hit1 = fwd_ex_valid && (fwd_ex_rd == in_rs1_addr) && (in_rs1_addr != '0);
        wb_hit1 = fwd_wb_valid && (fwd_wb_rd == in_rs1_addr) && (in_rs1_addr != '0);
        ex_hit2 = !in_use_imm && fwd_ex_valid && (fwd_ex_rd == in_rs2_addr)
                  && (in_rs2_addr != '0);
        wb_hit2 = !in_use_imm && fwd_wb_valid && (fwd_wb_rd == in_rs2_addr)
                  && (in_rs2_addr != '0);

        // EX is the younger result, so it is applied last and wins over WB.
        rs1_val = in_rs1_data;
        if (wb_hit1) rs1_val = fwd_wb_data;
        if (ex_hit1) rs1_val = fwd_ex_data;

        rs2_val = in_rs2_data;
        if (wb_hit2) rs2_val = fwd_wb_data;
        if (ex_hit2) rs2_val = fwd_ex_data;

        dec      = alu_decode(in_funct3, in_funct7b5, in_use_imm);
        stage_op = '{
            op1:       rs1_val,
            op2:       in_use_imm ? in_imm : rs2_val,
            selection: dec[2:0],
            illegal:   dec[3]
        };
    end

    alu_skid_buffer #(
        .Width    ($bits(alu_op_t)),
        .ResetVal (ALU_OP_RESET)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (stage_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_op)
    );

    assign op1        = out_op.op1;
    assign op2        = out_op.op2;
    assign selection  = out_op.selection;
    assign illegal_op = out_op.illegal;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: expected ops are queued on accept and compared
// in order as the stage hands them to the ALU.
module tb_alu_operand_stage;
    import alu_pkg::*;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned RADDR = 5;

    logic             clk = 1'b0;
    logic             rst, flush, in_valid, in_ready;
    logic [RADDR-1:0] in_rs1_addr, in_rs2_addr;
    logic [XLEN-1:0]  in_rs1_data, in_rs2_data, in_imm;
    logic             in_use_imm, in_funct7b5;
    logic [2:0]       in_funct3;
    logic             fwd_ex_valid, fwd_wb_valid;
    logic [RADDR-1:0] fwd_ex_rd, fwd_wb_rd;
    logic [XLEN-1:0]  fwd_ex_data, fwd_wb_data;
    logic             out_valid, out_ready;
    logic [XLEN-1:0]  op1, op2;
    logic [2:0]       selection;
    logic             illegal_op;

    int      n_cmp = 0;
    int      n_bad = 0;
    int      n_xfer = 0;
    alu_op_t sb[$];

    always #5 clk = ~clk;

    alu_operand_stage #(.XLEN(XLEN), .RADDR(RADDR)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rs1_addr  (in_rs1_addr),
        .in_rs2_addr  (in_rs2_addr),
        .in_rs1_data  (in_rs1_data),
        .in_rs2_data  (in_rs2_data),
        .in_imm       (in_imm),
        .in_use_imm   (in_use_imm),
        .in_funct3    (in_funct3),
        .in_funct7b5  (in_funct7b5),
        .fwd_ex_valid (fwd_ex_valid),
        .fwd_ex_rd    (fwd_ex_rd),
        .fwd_ex_data  (fwd_ex_data),
        .fwd_wb_valid (fwd_wb_valid),
        .fwd_wb_rd    (fwd_wb_rd),
        .fwd_wb_data  (fwd_wb_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .op1          (op1),
        .op2          (op2),
        .selection    (selection),
        .illegal_op   (illegal_op)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] ref_src(input logic [RADDR-1:0] addr,
                                                input logic [XLEN-1:0]  rf);
        if (addr == 0) return rf;
        if (fwd_ex_valid && fwd_ex_rd == addr) return fwd_ex_data;
        if (fwd_wb_valid && fwd_wb_rd == addr) return fwd_wb_data;
        return rf;
    endfunction

    function automatic alu_op_t ref_op();
        alu_op_t r;
        logic    rsub;
        rsub        = in_funct7b5 && !in_use_imm;
        r.op1       = ref_src(in_rs1_addr, in_rs1_data);
        r.op2       = in_use_imm ? in_imm : ref_src(in_rs2_addr, in_rs2_data);
        r.illegal   = 1'b0;
        r.selection = 3'b100;
        if (rsub && in_funct3 != 3'b000) begin
            r.illegal = 1'b1;
        end else begin
            case (in_funct3)
                3'b000:  r.selection = rsub ? 3'b101 : 3'b100;
                3'b111:  r.selection = 3'b110;
                3'b110:  r.selection = 3'b111;
                3'b100:  r.selection = 3'b000;
                3'b011:  r.selection = 3'b001;
                default: r.illegal = 1'b1;
            endcase
        end
        return r;
    endfunction

    // Monitor: pop on output transfer, push on accept; flush and reset discard held ops.
    always @(negedge clk) begin
        alu_op_t e;
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_xfer++;
                check_eq("sb_pending", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check_eq("sb_op1", op1, e.op1);
                    check_eq("sb_op2", op2, e.op2);
                    check_eq("sb_sel", selection, e.selection);
                    check_eq("sb_illegal", illegal_op, e.illegal);
                end
            end
            if (flush) sb.delete();
            else if (in_valid && in_ready) sb.push_back(ref_op());
        end
    end

    task automatic set_fwd(input logic exv, input logic [RADDR-1:0] exrd, input logic [XLEN-1:0] exd,
                           input logic wbv, input logic [RADDR-1:0] wbrd, input logic [XLEN-1:0] wbd);
        fwd_ex_valid = exv; fwd_ex_rd = exrd; fwd_ex_data = exd;
        fwd_wb_valid = wbv; fwd_wb_rd = wbrd; fwd_wb_data = wbd;
    endtask

    task automatic drive_op(input logic [RADDR-1:0] a1, input logic [RADDR-1:0] a2,
                            input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                            input logic [XLEN-1:0] imm, input logic ui,
                            input logic [2:0] f3, input logic f7);
        in_rs1_addr = a1; in_rs2_addr = a2; in_rs1_data = d1; in_rs2_data = d2;
        in_imm = imm; in_use_imm = ui; in_funct3 = f3; in_funct7b5 = f7;
        in_valid = 1'b1;
    endtask

    task automatic wait_accept();
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("accept_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [RADDR-1:0] a1, input logic [RADDR-1:0] a2,
                        input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                        input logic [XLEN-1:0] imm, input logic ui,
                        input logic [2:0] f3, input logic f7);
        drive_op(a1, a2, d1, d2, imm, ui, f3, f7);
        wait_accept();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, cnt, drops;
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        set_fwd(1'b0, '0, '0, 1'b0, '0, '0);
        drive_op(5'd1, 5'd2, 32'h11, 32'h22, 32'h0, 1'b0, 3'b000, 1'b0);

        // Reset held 3 cycles with in_valid high
        repeat (3) begin
            @(negedge clk);
            check_eq("rst_out_valid", out_valid, 0);
            check_eq("rst_in_ready", in_ready, 0);
            check_eq("rst_sel", selection, 3'b100);
            check_eq("rst_op1", op1, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("rel_in_ready", in_ready, 1);
        check_eq("rel_out_valid", out_valid, 0);
        check_eq("rel_illegal", illegal_op, 0);
        @(posedge clk); #1;

        // Selection map
        send(5'd1, 5'd2, 32'd7, 32'd3, 32'd0, 1'b0, 3'b000, 1'b1);
        @(negedge clk);
        check_eq("map_sub_valid", out_valid, 1);
        check_eq("map_sub_op1", op1, 7);
        check_eq("map_sub_op2", op2, 3);
        check_eq("map_sub_sel", selection, 3'b101);
        @(posedge clk); #1;
        send(5'd1, 5'd2, 32'd7, 32'd3, 32'd5, 1'b1, 3'b000, 1'b1);
        @(negedge clk);
        check_eq("map_addi_sel", selection, 3'b100);
        check_eq("map_addi_op2", op2, 5);
        @(posedge clk); #1;
        send(5'd1, 5'd2, 32'd7, 32'd3, 32'd0, 1'b0, 3'b010, 1'b0);
        @(negedge clk);
        check_eq("map_f3_010_sel", selection, 3'b100);
        check_eq("map_f3_010_illegal", illegal_op, 1);
        @(posedge clk); #1;
        send(5'd1, 5'd2, 32'd7, 32'd3, 32'd0, 1'b0, 3'b111, 1'b1);
        @(negedge clk);
        check_eq("map_r_f7_illegal", illegal_op, 1);
        @(posedge clk); #1;
        send(5'd1, 5'd2, 32'd7, 32'd3, 32'd0, 1'b0, 3'b011, 1'b0);
        @(negedge clk);
        check_eq("map_sltu_sel", selection, 3'b001);
        @(posedge clk); #1;
        send(5'd1, 5'd2, 32'd7, 32'd3, 32'd0, 1'b0, 3'b110, 1'b0);
        @(negedge clk);
        check_eq("map_or_sel", selection, 3'b111);
        @(posedge clk); #1;

        // Forwarding priority and x0
        set_fwd(1'b1, 5'd4, 32'hAA, 1'b1, 5'd4, 32'hBB);
        send(5'd4, 5'd6, 32'h11, 32'h66, 32'd0, 1'b0, 3'b000, 1'b0);
        @(negedge clk);
        check_eq("fwd_ex_beats_wb", op1, 32'hAA);
        @(posedge clk); #1;
        set_fwd(1'b1, 5'd0, 32'hCC, 1'b1, 5'd9, 32'h55);
        send(5'd0, 5'd9, 32'h22, 32'h99, 32'd0, 1'b0, 3'b100, 1'b0);
        @(negedge clk);
        check_eq("fwd_x0_op1", op1, 32'h22);
        check_eq("fwd_wb_op2", op2, 32'h55);
        @(posedge clk); #1;
        set_fwd(1'b1, 5'd9, 32'hEE, 1'b0, '0, '0);
        send(5'd3, 5'd9, 32'h33, 32'h99, 32'h77, 1'b1, 3'b111, 1'b0);
        @(negedge clk);
        check_eq("fwd_imm_op2", op2, 32'h77);
        @(posedge clk); #1;
        set_fwd(1'b0, '0, '0, 1'b0, '0, '0);

        // Back-pressure: A in main, B in skid, C held by sender
        out_ready = 1'b0;
        send(5'd1, 5'd2, 32'hA, 32'h1, 32'd0, 1'b0, 3'b000, 1'b0);
        send(5'd1, 5'd2, 32'hB, 32'h2, 32'd0, 1'b0, 3'b111, 1'b0);
        drive_op(5'd1, 5'd2, 32'hC, 32'h3, 32'd0, 1'b0, 3'b110, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check_eq("bp_in_ready", in_ready, 0);
            check_eq("bp_out_valid", out_valid, 1);
            check_eq("bp_hold_op1", op1, 32'hA);
            @(posedge clk); #1;
        end
        base = n_xfer;
        out_ready = 1'b1;
        wait_accept();
        repeat (3) @(posedge clk);
        #1;
        check_eq("bp_drain_count", n_xfer - base, 3);
        check_eq("bp_sb_empty", sb.size(), 0);

        // Flush with both entries held and in_valid high
        out_ready = 1'b0;
        send(5'd1, 5'd2, 32'hD1, 32'h1, 32'd0, 1'b0, 3'b000, 1'b0);
        send(5'd1, 5'd2, 32'hD2, 32'h2, 32'd0, 1'b0, 3'b000, 1'b0);
        drive_op(5'd1, 5'd2, 32'hD3, 32'h3, 32'd0, 1'b0, 3'b000, 1'b0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check_eq("flush2_out_valid", out_valid, 0);
        check_eq("flush2_in_ready", in_ready, 1);
        out_ready = 1'b1;
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check_eq("flush2_silent", cnt, 0);

        // Flush with skid empty: the op accepted in the flush cycle is discarded too
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(5'd1, 5'd2, 32'hE1, 32'h1, 32'd0, 1'b0, 3'b000, 1'b0);
        drive_op(5'd1, 5'd2, 32'hE2, 32'h2, 32'd0, 1'b0, 3'b000, 1'b0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check_eq("flush1_silent", cnt, 0);

        // Reset mid-stream drops held ops
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(5'd1, 5'd2, 32'hF1, 32'h1, 32'd0, 1'b0, 3'b111, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_out_valid", out_valid, 0);
        check_eq("mid_rst_sel", selection, 3'b100);
        check_eq("mid_rst_op1", op1, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("mid_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Throughput: 16 back-to-back ops with randomised fields and forwarding
        base = n_xfer; cnt = 0; drops = 0;
        for (int i = 0; i < 16; i++) begin
            set_fwd(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                    1'($urandom), 5'($urandom_range(0, 7)), $urandom);
            drive_op(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, $urandom,
                     $urandom, 1'($urandom), 3'($urandom), 1'($urandom));
            @(negedge clk);
            if (!in_ready) drops++;
            if (i > 0 && out_valid) cnt++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        if (out_valid) cnt++;
        @(posedge clk); #1;
        check_eq("tp_in_ready_drops", drops, 0);
        check_eq("tp_out_valid_run", cnt, 16);
        check_eq("tp_xfer_count", n_xfer - base, 16);
        check_eq("tp_sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
